// File: rtl/multiplier_pkg.sv
// Shared types for the shift-and-add multiplier controller.
// Provides the FSM state encoding and the step counter width helper.
package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } mult_state_t;

    // Width of a counter that must hold values 0..n-1 (n >= 2).
    function automatic int step_count_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mult_step_counter.sv
// Loadable down-counter that tracks the remaining shift steps.
// Ports: clock, reset (sync, active-high), load_i/load_val_i load a value,
//        dec_i decrements, count_o current value, zero_o set when count is 0.
module mult_step_counter #(
    parameter int W = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load wins over decrement; decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/multiplier_controller.sv
// Sequencer for an N-bit shift-and-add multiplier datapath: one init
// cycle, N shift cycles, then the product is held on a valid/ready port.
// Ports: clock, reset (sync, active-high); start_valid/start_ready with
//        multiplicand_in/multiplier_in; result_valid/result_ready with
//        product; busy; do_init/do_shift, dp_multiplicand/dp_multiplier
//        and dp_product towards the datapath.
// Optional: define MULT_CTRL_ABORT_EN to add the abort input, which
//        returns any non-IDLE state to IDLE and drops a pending result.
module multiplier_controller
    import multiplier_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic [N-1:0]   multiplicand_in,
    input  logic [N-1:0]   multiplier_in,
    output logic           result_valid,
    input  logic           result_ready,
    output logic [2*N-1:0] product,
    output logic           busy,
    output logic           do_init,
    output logic           do_shift,
    output logic [N-1:0]   dp_multiplicand,
    output logic [N-1:0]   dp_multiplier,
`ifdef MULT_CTRL_ABORT_EN
    input  logic           abort,
`endif
    input  logic [2*N-1:0] dp_product
);

    localparam int CW = step_count_width(N);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    mult_state_t  state_q;
    mult_state_t  state_d;
    logic [N-1:0] mcand_q;
    logic [N-1:0] mplier_q;
    logic [CW-1:0] cnt_q;
    logic         cnt_zero;
    logic         cnt_load;
    logic         cnt_dec;
    logic         abort_act;
    logic         accept;

`ifdef MULT_CTRL_ABORT_EN
    // abort only matters once an operation is in flight.
    assign abort_act = abort && (state_q != IDLE);
`else
    assign abort_act = 1'b0;
`endif

    assign accept = start_valid && start_ready;

    mult_step_counter #(
        .W (CW)
    ) u_cnt (
        .clock      (clock),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (LAST_STEP),
        .dec_i      (cnt_dec),
        .count_o    (cnt_q),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start_valid) state_d = INIT;
            INIT:  state_d = SHIFT;
            SHIFT: if (cnt_zero) state_d = DONE;
            DONE: begin
                if (result_ready) begin
                    state_d = start_valid ? INIT : IDLE;
                end
            end
        endcase
        if (abort_act) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        start_ready  = 1'b0;
        result_valid = 1'b0;
        product      = '0;
        busy         = 1'b0;
        do_init      = 1'b0;
        do_shift     = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        unique case (state_q)
            IDLE: start_ready = 1'b1;
            INIT: begin
                busy     = 1'b1;
                do_init  = 1'b1;
                cnt_load = 1'b1;
            end
            SHIFT: begin
                busy     = 1'b1;
                do_shift = 1'b1;
                cnt_dec  = (cnt_q != '0);
            end
            DONE: begin
                result_valid = 1'b1;
                product      = dp_product;
                // An aborted DONE must not swallow a new operand pair.
                start_ready  = result_ready && !abort_act;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (accept) begin
            mcand_q  <= multiplicand_in;
            mplier_q <= multiplier_in;
        end
    end

    assign dp_multiplicand = mcand_q;
    assign dp_multiplier   = mplier_q;

endmodule

// File: doc/multiplier_controller.md
Name: multiplier_controller

Overview:
- Sequencer for the N-bit shift-and-add multiplier datapath.
- Accepts an operand pair over a valid/ready handshake and registers both operands.
- Drives the datapath's do_init and do_shift strobes: one init cycle, then exactly N shift cycles.
- Presents the 2N-bit product over a valid/ready result handshake. A top-level wrapper instantiates this block beside the datapath and ties datapath n_reset = ~reset.

Parameters:
- N, 4, operand width in bits; must match the datapath's N; legal range N >= 2.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start_valid  input  1  operand pair offered
- start_ready  output  1  controller can accept an operand pair
- multiplicand_in  input  N  multiplicand, sampled on start handshake
- multiplier_in  input  N  multiplier, sampled on start handshake
- result_valid  output  1  product available
- result_ready  input  1  consumer takes the product
- product  output  2N  result; zero when result_valid=0
- busy  output  1  high in INIT or SHIFT
- do_init  output  1  to datapath
- do_shift  output  1  to datapath
- dp_multiplicand  output  N  to datapath multiplicand, held stable for the whole operation
- dp_multiplier  output  N  to datapath multiplier
- dp_product  input  2N  from datapath product

Behaviour:
- Interface: one clock named clock; reset is synchronous and active-high, port named reset. All state changes occur on the rising edge of clock.
- FSM states: IDLE, INIT, SHIFT, DONE.
- Reset values: state=IDLE, step counter=0, operand registers=0. With state IDLE, all outputs are 0 except start_ready=1.
- IDLE: start_ready=1. If start_valid=1, latch both operands and go to INIT.
- INIT: do_init=1 for exactly one cycle. Load the step counter with N-1. Go to SHIFT.
- SHIFT: do_shift=1 every cycle. If counter==0, go to DONE; otherwise decrement the counter. Exactly N shift cycles occur.
- DONE: result_valid=1 and product=dp_product. do_init and do_shift are 0, so the datapath holds its value.
  - result_ready=1 and start_valid=0: go to IDLE.
  - result_ready=1 and start_valid=1: accept the new operands back-to-back and go to INIT. start_ready = (state==IDLE) | (state==DONE & result_ready).
  - result_ready=0: hold DONE indefinitely with the product stable.
- Latency: start handshake at edge k gives result_valid high in cycle k+N+2. Sustained throughput is one product per N+2 cycles.
- do_init and do_shift are never asserted in the same cycle.
- dp_multiplicand and dp_multiplier change only on an accepted start handshake.
- start_valid is ignored in INIT and SHIFT, and in DONE while result_ready=0.
- Counter width: $clog2(N). The counter value never exceeds N-1.
- Reset asserted mid-operation returns to IDLE on the next edge with no result emitted. The datapath resets concurrently through ~reset.
- Zero operands need no special case: 0*x and x*0 complete in the full N+2 cycles.

Optional Feature:
- Macro: MULT_CTRL_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 in INIT, SHIFT or DONE forces IDLE on the next edge and discards any pending result. abort takes priority over all other transitions. abort in IDLE has no effect, and the same-cycle start handshake still proceeds.
- Undefined: the abort port is absent, and every accepted operation runs to DONE.

Decomposition:
- Package multiplier_pkg: state enum type mult_state_t {IDLE, INIT, SHIFT, DONE}, and function step_count_width(N) returning $clog2(N).
- One natural sub-module: mult_step_counter, a loadable down-counter with load, decrement and zero-flag outputs. The FSM stays in multiplier_controller.

Test Plan:
- N=4, operands 13 and 11, result_ready=1 throughout: do_init for 1 cycle, do_shift for exactly 4 cycles, result_valid at k+6, product=8'h8F (143).
- 15*15 with result_ready=0 for 5 cycles after valid: product holds 8'hE1 (225), result_valid stays 1, start_ready=0, and do_shift remains 0.
- Back-to-back 3*5 then 7*9 with start_valid held high: second acceptance occurs in the DONE cycle of the first. Products are 8'h0F and 8'h3F, spaced 6 cycles apart.
- 0*9 and 9*0: product=0 after the full 6-cycle latency; busy is high for exactly 5 cycles.
- reset asserted during the 2nd SHIFT cycle: next cycle state=IDLE, start_ready=1, result_valid=0. A following 2*2 returns 8'h04.
- Build with MULT_CTRL_ABORT_EN: abort in SHIFT gives IDLE next cycle with no result_valid. abort in DONE drops the pending result.
